// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 64-bit MIPS datapath: operand bypassing from EX/MEM and MEM/WB,
// load-use hazard detection with a one-cycle bubble, and a saturating stall counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic [ADDR_W-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic              id_use_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exm_reg_write,
  input  logic [ADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [ADDR_W-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [3:0]        ex_alu_op,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [15:0]       stall_count
);

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] op_b;
  logic              exm_hit_rs, exm_hit_rt, mwb_hit_rs, mwb_hit_rt;

  // Register 0 is hard-wired, so a write targeting it never bypasses.
  assign exm_hit_rs = exm_reg_write && (exm_rd != '0) && (exm_rd == id_rs_addr);
  assign exm_hit_rt = exm_reg_write && (exm_rd != '0) && (exm_rd == id_rt_addr);
  assign mwb_hit_rs = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == id_rs_addr);
  assign mwb_hit_rt = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == id_rt_addr);

  always_comb begin
    fwd_rs = read_data_1;
    if (exm_hit_rs)      fwd_rs = exm_result;
    else if (mwb_hit_rs) fwd_rs = mwb_data;

    fwd_rt = read_data_2;
    if (exm_hit_rt)      fwd_rt = exm_result;
    else if (mwb_hit_rt) fwd_rt = mwb_data;

    op_b = id_use_imm ? id_imm : fwd_rt;
  end

  // A load in EX cannot bypass to ID yet; rt only matters when it is actually read.
  assign stall = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                 ((ex_rd == id_rs_addr) || ((ex_rd == id_rt_addr) && !id_use_imm)) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_op     <= '0;
      ex_rd         <= '0;
      ex_op_a       <= '0;
      ex_op_b       <= '0;
      ex_store_data <= '0;
    end else if (flush || stall) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_op     <= '0;
      ex_rd         <= '0;
      ex_op_a       <= '0;
      ex_op_b       <= '0;
      ex_store_data <= '0;
    end else begin
      ex_valid      <= id_valid;
      ex_reg_write  <= id_valid && id_reg_write;
      ex_mem_read   <= id_valid && id_mem_read;
      ex_mem_write  <= id_valid && id_mem_write;
      ex_alu_op     <= id_alu_op;
      ex_rd         <= id_rd_addr;
      ex_op_a       <= fwd_rs;
      ex_op_b       <= op_b;
      ex_store_data <= fwd_rt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX-register contents are queued when an ID instruction
// is driven and compared one edge later; stall and stall_count are checked at the points they move.
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sd;
  } ex_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [DATA_W-1:0] read_data_1, read_data_2, id_imm;
  logic [3:0]        id_alu_op;
  logic              id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic              exm_reg_write;
  logic [ADDR_W-1:0] exm_rd;
  logic [DATA_W-1:0] exm_result;
  logic              mwb_reg_write;
  logic [ADDR_W-1:0] mwb_rd;
  logic [DATA_W-1:0] mwb_data;
  logic              flush;
  logic              stall;
  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]        ex_alu_op;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_op_a, ex_op_b, ex_store_data;
  logic [15:0]       stall_count;

  int   vectors = 0;
  int   miscompares = 0;
  ex_t  sb[$];
  ex_t  obs;
  ex_t  expv;

  localparam logic [3:0] AluAdd = 4'h2;

  id_ex_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_op(ex_alu_op),
    .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic ex_t observed();
    ex_t o;
    o = '{v: ex_valid, rw: ex_reg_write, mr: ex_mem_read, mw: ex_mem_write, alu: ex_alu_op,
          rd: ex_rd, a: ex_op_a, b: ex_op_b, sd: ex_store_data};
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_ex(input string tag, input ex_t want);
    obs = observed();
    vectors++;
    assert (obs === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed v%b rw%b mr%b mw%b alu%h rd%0d a%h b%h sd%h expected v%b rw%b mr%b mw%b alu%h rd%0d a%h b%h sd%h",
             tag, obs.v, obs.rw, obs.mr, obs.mw, obs.alu, obs.rd, obs.a, obs.b, obs.sd,
             want.v, want.rw, want.mr, want.mw, want.alu, want.rd, want.a, want.b, want.sd);
    end
  endtask

  task automatic push(input logic v, input logic rw, input logic mr, input logic mw,
                      input logic [3:0] alu, input logic [4:0] rd,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] sd);
    sb.push_back('{v: v, rw: rw, mr: mr, mw: mw, alu: alu, rd: rd, a: a, b: b, sd: sd});
  endtask

  // Advance one edge; if an expectation is queued, it is what EX must now hold.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      expv = sb.pop_front();
      check_ex(tag, expv);
    end
  endtask

  task automatic idle_fwd();
    exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
    mwb_reg_write = 1'b0; mwb_rd = '0; mwb_data = '0;
    flush = 1'b0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] imm, input logic use_imm, input logic rw,
                        input logic mr, input logic mw);
    id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    read_data_1 = d1; read_data_2 = d2; id_imm = imm; id_alu_op = AluAdd;
    id_use_imm = use_imm; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  // lw r8, 4(r1) with r1 = 0x100
  task automatic drive_load_r8();
    set_id(1'b1, 5'd1, 5'd0, 5'd8, 64'h100, 64'h0, 64'd4, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // add r9, r8, r1
  task automatic drive_dep_add();
    set_id(1'b1, 5'd8, 5'd1, 5'd9, 64'h55, 64'h66, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with random inputs, including a clock edge while held.
    rst = 1'b0;
    set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1, 1'b1, 1'b1);
    exm_reg_write = 1'b1; exm_rd = 5'($urandom); exm_result = {$urandom, $urandom};
    mwb_reg_write = 1'b1; mwb_rd = 5'($urandom); mwb_data = {$urandom, $urandom};
    flush = 1'b0;
    #2;
    check_ex("reset_ex", '0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_count", 64'(stall_count), 64'd0);
    @(posedge clk); #1;
    check_ex("reset_held_ex", '0);
    rst = 1'b1;

    // add r3, r1, r2
    idle_fwd();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1, 1'b0, 1'b0, AluAdd, 5'd3, 64'd5, 64'd7, 64'd7);
    step("add_basic");

    // Forward priority on rs.
    set_id(1'b1, 5'd4, 5'd5, 5'd6, 64'h1, 64'h2, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    exm_reg_write = 1'b1; exm_rd = 5'd4; exm_result = 64'hAAAA;
    mwb_reg_write = 1'b1; mwb_rd = 5'd4; mwb_data = 64'hBBBB;
    push(1'b1, 1'b1, 1'b0, 1'b0, AluAdd, 5'd6, 64'hAAAA, 64'h2, 64'h2);
    step("fwd_exm_wins");
    exm_reg_write = 1'b0;
    push(1'b1, 1'b1, 1'b0, 1'b0, AluAdd, 5'd6, 64'hBBBB, 64'h2, 64'h2);
    step("fwd_mwb");
    exm_reg_write = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
    push(1'b1, 1'b1, 1'b0, 1'b0, AluAdd, 5'd6, 64'h1, 64'h2, 64'h2);
    step("fwd_r0_never");

    // rt bypass feeds store data even when the immediate takes operand b (sw-like).
    idle_fwd();
    exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 64'hC0DE;
    set_id(1'b1, 5'd4, 5'd5, 5'd0, 64'h40, 64'h2, 64'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0, 1'b1, AluAdd, 5'd0, 64'h40, 64'h10, 64'hC0DE);
    step("store_rt_fwd");

    // Invalid ID instruction gates control bits.
    idle_fwd();
    set_id(1'b0, 5'd1, 5'd2, 5'd7, 64'h9, 64'hA, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b0, AluAdd, 5'd7, 64'h9, 64'hA, 64'hA);
    step("invalid_gated");

    // Load-use: one stall, one bubble, then EX/MEM supplies the loaded value.
    drive_load_r8();
    push(1'b1, 1'b1, 1'b1, 1'b0, AluAdd, 5'd8, 64'h100, 64'd4, 64'h0);
    step("lw_enter");
    drive_dep_add();
    #1;
    check("lu_stall", 64'(stall), 64'd1);
    push(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 64'h0, 64'h0, 64'h0);
    step("lu_bubble");
    check("lu_count", 64'(stall_count), 64'd1);
    check("lu_stall_drop", 64'(stall), 64'd0);
    exm_reg_write = 1'b1; exm_rd = 5'd8; exm_result = 64'hDEAD;
    push(1'b1, 1'b1, 1'b0, 1'b0, AluAdd, 5'd9, 64'hDEAD, 64'h66, 64'h66);
    step("lu_resume");

    // addi r8, r2, 16 with rt = 8 does not stall behind lw r8.
    idle_fwd();
    drive_load_r8();
    push(1'b1, 1'b1, 1'b1, 1'b0, AluAdd, 5'd8, 64'h100, 64'd4, 64'h0);
    step("lw_enter2");
    set_id(1'b1, 5'd2, 5'd8, 5'd8, 64'h20, 64'h77, 64'd16, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("imm_no_stall", 64'(stall), 64'd0);
    push(1'b1, 1'b1, 1'b0, 1'b0, AluAdd, 5'd8, 64'h20, 64'd16, 64'h77);
    step("imm_proceed");

    // Flush overrides a load-use condition.
    drive_load_r8();
    push(1'b1, 1'b1, 1'b1, 1'b0, AluAdd, 5'd8, 64'h100, 64'd4, 64'h0);
    step("lw_enter3");
    drive_dep_add();
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(stall), 64'd0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 64'h0, 64'h0, 64'h0);
    step("flush_bubble");
    check("flush_count", 64'(stall_count), 64'd1);
    flush = 1'b0;

    // Saturation: 65,537 more stalls on top of the one already counted.
    for (int i = 0; i < 65537; i++) begin
      drive_load_r8();
      step("sat_lw");
      drive_dep_add();
      step("sat_stall");
      if (i == 65532) check("count_fffe", 64'(stall_count), 64'hFFFE);
    end
    check("count_sat", 64'(stall_count), 64'hFFFF);

    // Async reset in the middle of a stall cycle.
    drive_load_r8();
    step("lw_enter4");
    drive_dep_add();
    #1;
    check("pre_rst_stall", 64'(stall), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_count", 64'(stall_count), 64'd0);
    check_ex("rst_ex", '0);
    #1;
    rst = 1'b1;
    sb.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 64-bit MIPS datapath. It sits directly downstream of `register_file` and captures `read_data_1`/`read_data_2` plus decoded control into the EX pipeline register. It resolves operand bypassing from EX/MEM and MEM/WB and detects load-use hazards. On a load-use hazard it stalls IF/ID and inserts a bubble into EX.

## Interface

- `DATA_W`, 64, datapath width
- `ADDR_W`, 5, register address width
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `id_valid` in 1: ID holds a valid instruction
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr` in ADDR_W: source and destination register numbers; `id_rs_addr`/`id_rt_addr` also drive the register file read addresses
- `read_data_1`, `read_data_2` in DATA_W: register file read data for rs and rt
- `id_imm` in DATA_W: sign-extended immediate
- `id_alu_op` in 4, `id_use_imm` in 1, `id_reg_write` in 1, `id_mem_read` in 1, `id_mem_write` in 1: decoded control
- `exm_reg_write` in 1, `exm_rd` in ADDR_W, `exm_result` in DATA_W: EX/MEM writeback candidate
- `mwb_reg_write` in 1, `mwb_rd` in ADDR_W, `mwb_data` in DATA_W: MEM/WB writeback; the same signals drive the register file write port
- `flush` in 1: branch/jump squash of the ID instruction
- `stall` out 1: hold PC and IF/ID (combinational)
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered control
- `ex_alu_op` out 4, `ex_rd` out ADDR_W: registered
- `ex_op_a`, `ex_op_b`, `ex_store_data` out DATA_W: registered operands
- `stall_count` out 16: saturating count of stall cycles

## Operation

**Forwarding (per source, rs and rt independently)**
- Selection priority:
  1. If `exm_reg_write`, `exm_rd` != 0 and `exm_rd` == src, select `exm_result`.
  2. Else if `mwb_reg_write`, `mwb_rd` != 0 and `mwb_rd` == src, select `mwb_data`. This covers the register-file write-then-read race.
  3. Else select `read_data_1` or `read_data_2`.
- Register 0 is never forwarded. The forwarded value for source 0 is the register file output.

**Operand selection**
- `ex_op_a` = forwarded rs.
- `ex_op_b` = `id_imm` if `id_use_imm`, else forwarded rt.
- `ex_store_data` = forwarded rt, always.

**Load-use hazard**
- `stall` = `id_valid` & `ex_valid` & `ex_mem_read` & (`ex_rd` != 0) & (`ex_rd` == `id_rs_addr` | (`ex_rd` == `id_rt_addr` & !`id_use_imm`)) & !`flush`.

**Pipeline register update, each rising edge, in priority order**
1. `flush`: load a bubble.
2. `stall`: load a bubble. The ID instruction is re-presented next cycle because IF/ID holds.
3. Otherwise: load the ID instruction. `ex_valid` = `id_valid`. Control bits are gated by `id_valid`.

**Bubble definition**
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` = 0.
- Data fields and `ex_rd` are don't-care; the implementation clears them to 0.

**`stall_count`**
- Increments on each edge where `stall` = 1.
- Saturates at 0xFFFF.

## Timing

- Reset (`rst` = 0, async): every registered output is 0 and `stall_count` = 0. `stall` is 0 because it is derived from `ex_valid` = 0.
- Latency: ID inputs appear on the `ex_*` outputs one cycle later.
- Load-use stall lasts exactly 1 cycle per hazard. The next cycle the load has moved to EX/MEM, and EX/MEM forwarding supplies the loaded value from the MEM stage.
- `flush` and `stall` in the same cycle: `stall` is forced to 0 and a bubble is inserted.
- `exm` and `mwb` both match a source: `exm` wins (youngest value).
- Reset asserted mid-stall: `stall` drops immediately (asynchronous through `ex_valid`). No state is retained.
- `stall_count` does not wrap past 0xFFFF.

## Test plan

- **Reset:** `rst` = 0 with random inputs -> all `ex_*` = 0, `stall` = 0, `stall_count` = 0. Release; ID `add r3,r1,r2` with `read_data_1` = 5, `read_data_2` = 7 -> next cycle `ex_op_a` = 5, `ex_op_b` = 7, `ex_rd` = 3, `ex_reg_write` = 1.
- **Forward priority:** ID rs = 4; `exm_rd` = 4, `exm_result` = 0xAAAA; `mwb_rd` = 4, `mwb_data` = 0xBBBB; `read_data_1` = 0x1 -> `ex_op_a` = 0xAAAA. Drop `exm_reg_write` -> 0xBBBB. Set `exm_rd` = `mwb_rd` = 0 with both write enables = 1 -> `ex_op_a` = 0x1.
- **Load-use:** `lw r8` in EX, then ID `add r9,r8,r1` -> `stall` = 1 for one cycle, the EX output is a bubble (`ex_valid` = 0) and `stall_count` = 1. The next cycle `add` proceeds with `ex_op_a` = `exm_result`.
- **Immediate does not stall on rt:** `lw r8` in EX, ID `addi r8,r2,16` with `id_use_imm` = 1 and rt = 8 -> `stall` = 0, `ex_op_b` = 16.
- **Flush vs stall:** a load-use condition with `flush` = 1 -> `stall` = 0 and `ex_valid` = 0 next cycle.
- **Counter saturation:** force 65,537 stall cycles -> `stall_count` = 0xFFFF. Async `rst` pulse mid-stall -> immediate zero.
